// File: rtl/mem_arb_pkg.sv
// +----------------------------------------------------------------------+
// | mem_arb_pkg : shared types and constants for the memory arbiter      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package mem_arb_pkg;

  localparam int ARB_ADDR_W = 28;
  localparam int ARB_DATA_W = 128;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GNT_I   = 2'd1,
    S_GNT_D   = 2'd2,
    S_RELEASE = 2'd3
  } arb_state_t;

  localparam logic GID_I = 1'b0;
  localparam logic GID_D = 1'b1;

  // On a tie the side that was not served last wins.
  function automatic logic rr_pick(input logic req_i, input logic req_d, input logic last);
    if (req_i && req_d) return ~last;
    return req_d ? GID_D : GID_I;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// +----------------------------------------------------------------------+
// | mem_arbiter_if : one block-memory channel (request + completion)     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) ();

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// +----------------------------------------------------------------------+
// | mem_arbiter : round-robin share of one memory port by I$ and D$      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  ic,
  mem_arbiter_if.slave  dc,
  mem_arbiter_if.master mem
);

  arb_state_t        r_state;
  logic              r_last_grant;

  logic              w_req_i;
  logic              w_req_d;
  logic              w_pick;
  logic              w_sel_read;
  logic              w_sel_write;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  assign w_req_i = ic.mem_read | ic.mem_write;
  assign w_req_d = dc.mem_read | dc.mem_write;
  assign w_pick  = rr_pick(w_req_i, w_req_d, r_last_grant);

  assign w_sel_read  = (w_pick == GID_D) ? dc.mem_read  : ic.mem_read;
  assign w_sel_write = (w_pick == GID_D) ? dc.mem_write : ic.mem_write;
  assign w_sel_addr  = (w_pick == GID_D) ? dc.mem_addr  : ic.mem_addr;
  assign w_sel_wdata = (w_pick == GID_D) ? dc.mem_wdata : ic.mem_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_last_grant  <= GID_I;
      mem.mem_read  <= 1'b0;
      mem.mem_write <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_i || w_req_d) begin
            r_state       <= (w_pick == GID_D) ? S_GNT_D : S_GNT_I;
            r_last_grant  <= w_pick;
            // A request carrying both read and write is treated as a write.
            mem.mem_write <= w_sel_write;
            mem.mem_read  <= w_sel_read & ~w_sel_write;
            mem.mem_addr  <= w_sel_addr;
            mem.mem_wdata <= w_sel_wdata;
          end
        end
        S_GNT_I, S_GNT_D: begin
          if (mem.mem_ready) begin
            r_state       <= S_RELEASE;
            mem.mem_read  <= 1'b0;
            mem.mem_write <= 1'b0;
          end
        end
        S_RELEASE: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  // Completion is forwarded in the same cycle, only to the granted side.
  assign ic.mem_ready = (r_state == S_GNT_I) & mem.mem_ready;
  assign dc.mem_ready = (r_state == S_GNT_D) & mem.mem_ready;
  assign ic.mem_rdata = mem.mem_rdata;
  assign dc.mem_rdata = mem.mem_rdata;

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single off-chip memory port between the instruction-cache and data-cache miss/write-back paths. It sits between both caches' memory-side interfaces and the main memory, below the RISCV_Pipeline core's ICACHE/DCACHE ports. It grants one requester at a time with round-robin fairness, latches the granted request onto the memory bus, and routes mem_ready and mem_rdata back to that requester only.

Parameters:
ADDR_W, 28, memory block address width (byte address >> 4)
DATA_W, 128, memory block width in bits

Ports:
clk  in  1  clock, single domain
rst_n  in  1  reset; asynchronous assert, active-low
ic_mem_read  in  1  I-cache block read request, held high until ic_mem_ready
ic_mem_write  in  1  I-cache block write request; normally 0, supported for symmetry
ic_mem_addr  in  ADDR_W  I-cache block address
ic_mem_wdata  in  DATA_W  I-cache write data
ic_mem_rdata  out  DATA_W  read data to I-cache
ic_mem_ready  out  1  one-cycle completion pulse to I-cache
dc_mem_read  in  1  D-cache block read request, held high until dc_mem_ready
dc_mem_write  in  1  D-cache write-back request, held high until dc_mem_ready
dc_mem_addr  in  ADDR_W  D-cache block address
dc_mem_wdata  in  DATA_W  D-cache write data
dc_mem_rdata  out  DATA_W  read data to D-cache
dc_mem_ready  out  1  one-cycle completion pulse to D-cache
mem_read  out  1  read request to memory, registered
mem_write  out  1  write request to memory, registered
mem_addr  out  ADDR_W  address to memory, registered
mem_wdata  out  DATA_W  write data to memory, registered
mem_rdata  in  DATA_W  read data from memory
mem_ready  in  1  memory completion pulse

Behaviour:
- Reset (async, rst_n=0): state=IDLE, last_grant=I. mem_read, mem_write, mem_addr and mem_wdata are 0. ic_mem_ready and dc_mem_ready are 0. Aborts any in-flight transaction with no completion pulse.
- States: IDLE, GNT_I, GNT_D, RELEASE.
- IDLE: req_x = x_mem_read | x_mem_write.
  - If only one requester is active, grant it.
  - If both are active, grant the one not equal to last_grant (after reset, D wins the first tie).
  - On grant, at the next edge: move to GNT_x, set last_grant=x, and latch x's addr, wdata, read and write into the mem_* registers.
  - If x asserts both read and write, write wins: mem_write=1, mem_read=0.
  - Latency: request seen in cycle t gives mem_read/mem_write high in cycle t+1.
- GNT_x: mem_* hold their latched values; requester inputs are ignored.
  - When mem_ready=1: x_mem_ready=mem_ready combinationally in the same cycle. x_mem_rdata passes mem_rdata through.
  - Next state is RELEASE, with mem_read and mem_write cleared at that edge. mem_addr and mem_wdata hold.
- RELEASE: memory request is low for exactly one cycle; all requests are ignored. Next state is IDLE.
  - The minimum spacing between consecutive memory requests is therefore 2 idle cycles after mem_ready.
- Non-granted side: x_mem_ready is 0 at all times. x_mem_rdata is driven by mem_rdata to both sides; only the ready pulse qualifies it.
- mem_ready seen in IDLE or RELEASE is ignored: no ready is forwarded and no state change occurs.
- A requester that drops its request while granted has no effect; the transaction completes on the memory side and the pulse is still issued.
- Fairness: under continuous requests from both sides, grants strictly alternate I, D, I, D.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding localparams S_IDLE=2'd0, S_GNT_I=2'd1, S_GNT_D=2'd2, S_RELEASE=2'd3
  - grant-id constants GID_I=1'b0, GID_D=1'b1
  - default ADDR_W and DATA_W
- The block is a single module with no sub-module; the round-robin pick is a 2-input expression.

Test Plan:
- I-cache read only: ic_mem_read=1, addr=28'h0000010; memory ready after 5 cycles with rdata=128'hA5... -> mem_read=1, mem_addr=28'h0000010 one cycle after the request; ic_mem_ready pulses 1 cycle with rdata=A5...; dc_mem_ready stays 0; mem_read=0 for 1 cycle, then IDLE.
- D-cache write-back: dc_mem_write=1, addr=28'h0000200, wdata=128'h1234... -> mem_write=1 with matching addr and wdata; mem_read=0; dc_mem_ready pulses once on mem_ready.
- Simultaneous requests after reset: I read at 0x10 and D read at 0x20 in the same cycle -> D granted first (mem_addr=0x20); after its RELEASE, I is granted (mem_addr=0x10).
- Starvation check: I is held high while D re-requests immediately after each dc_mem_ready, for 4 transactions -> memory sees alternating addresses I, D, I, D.
- Reset mid-transaction: rst_n=0 two cycles into GNT_D -> mem_read/mem_write drop asynchronously; no dc_mem_ready pulse; after release, a new I request is granted normally.
- Stray mem_ready: pulse mem_ready while IDLE with no requests -> both ready outputs stay 0; state stays IDLE.
